// File: rtl/apb_splitter_pkg.sv
// Shared definitions for the APB 1-to-N splitter: FSM state encodings and width helpers.
package apb_splitter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_ACCESS = 3'd2;
  localparam state_t ST_RESP   = 3'd3;
  localparam state_t ST_ERR    = 3'd4;

  // Slave index field width; a single slave still needs one index bit.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

  function automatic int byte_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational upstream address decode: slave index field and hit flag.
module apb_addr_decode
  import apb_splitter_pkg::*;
#(
  parameter int G_ADDR_WIDTH   = 7,
  parameter int G_NUM_SLAVES   = 8,
  parameter int G_S_ADDR_WIDTH = 12,
  parameter int G_SEL_WIDTH    = sel_width(8)
) (
  input  logic [G_S_ADDR_WIDTH-1:0] paddr,
  output logic [G_SEL_WIDTH-1:0]    idx,
  output logic                      hit
);

  logic in_range;
  logic upper_zero;

  assign idx        = paddr[G_ADDR_WIDTH +: G_SEL_WIDTH];
  assign in_range   = (32'(idx) < 32'(G_NUM_SLAVES));
  // Any set bit above the index field aliases no slave.
  assign upper_zero = ((paddr >> (G_ADDR_WIDTH + G_SEL_WIDTH)) == '0);
  assign hit        = in_range && upper_zero;

endmodule

// File: rtl/apb_splitter.sv
// Registered APB 1-to-N splitter. Optional ACCESS timeout enabled by defining
// APB_SPLITTER_TIMEOUT_EN (limit set by G_TIMEOUT).
module apb_splitter
  import apb_splitter_pkg::*;
#(
  parameter int G_REGWIDTH     = 32,
  parameter int G_ADDR_WIDTH   = 7,
  parameter int G_NUM_SLAVES   = 8,
  parameter int G_S_ADDR_WIDTH = 12,
  parameter int G_TIMEOUT      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_apb_psel,
  input  logic                               s_apb_penable,
  input  logic                               s_apb_pwrite,
  input  logic [2:0]                         s_apb_pprot,
  input  logic [G_S_ADDR_WIDTH-1:0]          s_apb_paddr,
  input  logic [G_REGWIDTH-1:0]              s_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]            s_apb_pstrb,
  output logic                               s_apb_pready,
  output logic [G_REGWIDTH-1:0]              s_apb_prdata,
  output logic                               s_apb_pslverr,
  output logic [G_NUM_SLAVES-1:0]            m_apb_psel,
  output logic                               m_apb_penable,
  output logic                               m_apb_pwrite,
  output logic [2:0]                         m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]            m_apb_paddr,
  output logic [G_REGWIDTH-1:0]              m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]            m_apb_pstrb,
  input  logic [G_NUM_SLAVES-1:0]            m_apb_pready,
  input  logic [G_NUM_SLAVES*G_REGWIDTH-1:0] m_apb_prdata,
  input  logic [G_NUM_SLAVES-1:0]            m_apb_pslverr
);

  localparam int G_SEL_WIDTH  = sel_width(G_NUM_SLAVES);
  localparam int G_STRB_WIDTH = byte_width(G_REGWIDTH);

  state_t                    state;
  logic                      cap_write;
  logic [2:0]                cap_prot;
  logic [G_ADDR_WIDTH-1:0]   cap_addr;
  logic [G_REGWIDTH-1:0]     cap_wdata;
  logic [G_STRB_WIDTH-1:0]   cap_strb;
  logic [G_SEL_WIDTH-1:0]    cap_idx;
  logic [G_REGWIDTH-1:0]     rsp_data;
  logic                      rsp_err;

  logic [G_SEL_WIDTH-1:0]    dec_idx;
  logic                      dec_hit;
  logic                      setup_req;
  logic                      active;
  logic                      sel_pready;
  logic                      sel_pslverr;
  logic [G_REGWIDTH-1:0]     sel_prdata;
  logic                      tmo_hit;

  apb_addr_decode #(
    .G_ADDR_WIDTH   (G_ADDR_WIDTH),
    .G_NUM_SLAVES   (G_NUM_SLAVES),
    .G_S_ADDR_WIDTH (G_S_ADDR_WIDTH),
    .G_SEL_WIDTH    (G_SEL_WIDTH)
  ) u_decode (
    .paddr (s_apb_paddr),
    .idx   (dec_idx),
    .hit   (dec_hit)
  );

  assign setup_req   = s_apb_psel && !s_apb_penable;
  assign sel_pready  = m_apb_pready[cap_idx];
  assign sel_pslverr = m_apb_pslverr[cap_idx];
  assign sel_prdata  = m_apb_prdata[int'(cap_idx)*G_REGWIDTH +: G_REGWIDTH];

`ifdef APB_SPLITTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(G_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ST_ACCESS && !sel_pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the last permitted ACCESS cycle so ACCESS lasts exactly G_TIMEOUT cycles.
  assign tmo_hit = (tmo_cnt == TMO_W'(G_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (setup_req) state <= dec_hit ? ST_SETUP : ST_ERR;
        ST_SETUP:  state <= ST_ACCESS;
        ST_ACCESS: if (sel_pready || tmo_hit) state <= ST_RESP;
        ST_RESP:   state <= ST_IDLE;
        ST_ERR:    state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Transfer and response payload; never seen outside the states that qualify it.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && setup_req) begin
      cap_write <= s_apb_pwrite;
      cap_prot  <= s_apb_pprot;
      cap_addr  <= s_apb_paddr[G_ADDR_WIDTH-1:0];
      cap_wdata <= s_apb_pwdata;
      cap_strb  <= s_apb_pstrb;
      cap_idx   <= dec_idx;
    end
    if (state == ST_ACCESS) begin
      if (sel_pready) begin
        rsp_data <= cap_write ? '0 : sel_prdata;
        rsp_err  <= sel_pslverr;
      end else if (tmo_hit) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign active        = (state == ST_SETUP) || (state == ST_ACCESS);
  assign m_apb_psel    = active ? (G_NUM_SLAVES'(1) << cap_idx) : '0;
  assign m_apb_penable = (state == ST_ACCESS);
  assign m_apb_pwrite  = active && cap_write;
  assign m_apb_pprot   = active ? cap_prot  : '0;
  assign m_apb_paddr   = active ? cap_addr  : '0;
  assign m_apb_pwdata  = active ? cap_wdata : '0;
  assign m_apb_pstrb   = active ? cap_strb  : '0;

  assign s_apb_pready  = (state == ST_RESP) || (state == ST_ERR);
  assign s_apb_prdata  = (state == ST_RESP) ? rsp_data : '0;
  assign s_apb_pslverr = ((state == ST_RESP) && rsp_err) || (state == ST_ERR);

endmodule

// File: tb/tb_apb_splitter.sv
// Directed bench for apb_splitter: decode, wait states, miss, slave error, reset, optional timeout.
module tb_apb_splitter;

  localparam int RW  = 32;
  localparam int AW  = 7;
  localparam int NS  = 8;
  localparam int SAW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_apb_psel, s_apb_penable, s_apb_pwrite;
  logic [2:0]        s_apb_pprot;
  logic [SAW-1:0]    s_apb_paddr;
  logic [RW-1:0]     s_apb_pwdata;
  logic [RW/8-1:0]   s_apb_pstrb;
  logic              s_apb_pready;
  logic [RW-1:0]     s_apb_prdata;
  logic              s_apb_pslverr;
  logic [NS-1:0]     m_apb_psel;
  logic              m_apb_penable, m_apb_pwrite;
  logic [2:0]        m_apb_pprot;
  logic [AW-1:0]     m_apb_paddr;
  logic [RW-1:0]     m_apb_pwdata;
  logic [RW/8-1:0]   m_apb_pstrb;
  logic [NS-1:0]     m_apb_pready;
  logic [NS*RW-1:0]  m_apb_prdata;
  logic [NS-1:0]     m_apb_pslverr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_splitter dut (
    .clk           (clk),
    .rst           (rst),
    .s_apb_psel    (s_apb_psel),
    .s_apb_penable (s_apb_penable),
    .s_apb_pwrite  (s_apb_pwrite),
    .s_apb_pprot   (s_apb_pprot),
    .s_apb_paddr   (s_apb_paddr),
    .s_apb_pwdata  (s_apb_pwdata),
    .s_apb_pstrb   (s_apb_pstrb),
    .s_apb_pready  (s_apb_pready),
    .s_apb_prdata  (s_apb_prdata),
    .s_apb_pslverr (s_apb_pslverr),
    .m_apb_psel    (m_apb_psel),
    .m_apb_penable (m_apb_penable),
    .m_apb_pwrite  (m_apb_pwrite),
    .m_apb_pprot   (m_apb_pprot),
    .m_apb_paddr   (m_apb_paddr),
    .m_apb_pwdata  (m_apb_pwdata),
    .m_apb_pstrb   (m_apb_pstrb),
    .m_apb_pready  (m_apb_pready),
    .m_apb_prdata  (m_apb_prdata),
    .m_apb_pslverr (m_apb_pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_slave_data(input int i, input logic [RW-1:0] d);
    m_apb_prdata[i*RW +: RW] = d;
  endtask

  task automatic up_setup(input logic [SAW-1:0] addr, input logic wr,
                          input logic [RW-1:0] wdata, input logic [3:0] strb);
    s_apb_psel    = 1'b1;
    s_apb_penable = 1'b0;
    s_apb_paddr   = addr;
    s_apb_pwrite  = wr;
    s_apb_pwdata  = wdata;
    s_apb_pstrb   = strb;
  endtask

  task automatic up_idle();
    s_apb_psel    = 1'b0;
    s_apb_penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_apb_psel = 1'b0; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0;
    s_apb_pprot = 3'b000; s_apb_paddr = '0; s_apb_pwdata = '0; s_apb_pstrb = '0;
    m_apb_pready = '0; m_apb_pslverr = '0; m_apb_prdata = '0;
    for (int i = 0; i < NS; i++) set_slave_data(i, 32'hA000_0000 + 32'(i));

    // Reset state
    cyc(); cyc();
    chk("rst_psel",    m_apb_psel, 8'h00);
    chk("rst_penable", m_apb_penable, 1'b0);
    chk("rst_pwrite",  m_apb_pwrite, 1'b0);
    chk("rst_paddr",   m_apb_paddr, 7'h00);
    chk("rst_pwdata",  m_apb_pwdata, 32'h0);
    chk("rst_pready",  s_apb_pready, 1'b0);
    chk("rst_prdata",  s_apb_prdata, 32'h0);
    chk("rst_pslverr", s_apb_pslverr, 1'b0);
    rst = 1'b0;
    cyc();

    // Write 0xDEADBEEF to 0x0A4 (slave 1, offset 0x24), zero-wait slave
    up_setup(12'h0A4, 1'b1, 32'hDEAD_BEEF, 4'hF);
    s_apb_pprot = 3'b010;
    m_apb_pready = 8'hFF;
    set_slave_data(1, 32'h55AA_55AA);
    cyc();
    chk("w1_setup_psel",    m_apb_psel, 8'b0000_0010);
    chk("w1_setup_penable", m_apb_penable, 1'b0);
    chk("w1_setup_paddr",   m_apb_paddr, 7'h24);
    chk("w1_setup_pwdata",  m_apb_pwdata, 32'hDEAD_BEEF);
    chk("w1_setup_pwrite",  m_apb_pwrite, 1'b1);
    chk("w1_setup_pstrb",   m_apb_pstrb, 4'hF);
    chk("w1_setup_pprot",   m_apb_pprot, 3'b010);
    chk("w1_setup_pready",  s_apb_pready, 1'b0);
    s_apb_penable = 1'b1;
    cyc();
    chk("w1_acc_psel",    m_apb_psel, 8'b0000_0010);
    chk("w1_acc_penable", m_apb_penable, 1'b1);
    chk("w1_acc_paddr",   m_apb_paddr, 7'h24);
    chk("w1_acc_pready",  s_apb_pready, 1'b0);
    cyc();
    chk("w1_resp_pready",  s_apb_pready, 1'b1);
    chk("w1_resp_pslverr", s_apb_pslverr, 1'b0);
    chk("w1_resp_prdata",  s_apb_prdata, 32'h0);
    chk("w1_resp_psel",    m_apb_psel, 8'h00);
    chk("w1_resp_penable", m_apb_penable, 1'b0);
    up_idle();
    cyc();
    chk("w1_idle_pready", s_apb_pready, 1'b0);

    // Read 0x390 (slave 7, offset 0x10), four wait states; other slaves assert ready/error
    up_setup(12'h390, 1'b0, 32'h0, 4'hF);
    s_apb_pprot = 3'b000;
    m_apb_pready = 8'h7F;
    m_apb_pslverr = 8'h7F;
    set_slave_data(7, 32'h0000_0000);
    cyc();
    chk("r7_setup_psel",  m_apb_psel, 8'h80);
    chk("r7_setup_paddr", m_apb_paddr, 7'h10);
    chk("r7_setup_pwrite", m_apb_pwrite, 1'b0);
    s_apb_penable = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("r7_wait_psel",    m_apb_psel, 8'h80);
      chk("r7_wait_penable", m_apb_penable, 1'b1);
      chk("r7_wait_pready",  s_apb_pready, 1'b0);
      cyc();
    end
    chk("r7_last_psel", m_apb_psel, 8'h80);
    m_apb_pready = 8'hFF;
    set_slave_data(7, 32'h1234_5678);
    cyc();
    chk("r7_resp_pready",  s_apb_pready, 1'b1);
    chk("r7_resp_prdata",  s_apb_prdata, 32'h1234_5678);
    chk("r7_resp_pslverr", s_apb_pslverr, 1'b0);
    chk("r7_resp_psel",    m_apb_psel, 8'h00);
    up_idle();
    m_apb_pslverr = 8'h00;
    cyc();
    chk("r7_idle_pready", s_apb_pready, 1'b0);
    chk("r7_idle_prdata", s_apb_prdata, 32'h0);

    // Read 0x400: bit above index field set -> miss, error at T+1
    up_setup(12'h400, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("miss_pready",  s_apb_pready, 1'b1);
    chk("miss_pslverr", s_apb_pslverr, 1'b1);
    chk("miss_prdata",  s_apb_prdata, 32'h0);
    chk("miss_psel",    m_apb_psel, 8'h00);
    chk("miss_penable", m_apb_penable, 1'b0);
    up_idle();
    cyc();
    chk("miss_idle_pready",  s_apb_pready, 1'b0);
    chk("miss_idle_pslverr", s_apb_pslverr, 1'b0);
    chk("miss_idle_psel",    m_apb_psel, 8'h00);

    // Write to slave 3 (0x185) with slave error, then back-to-back read of slave 0
    up_setup(12'h185, 1'b1, 32'h0BAD_F00D, 4'h3);
    m_apb_pslverr = 8'h08;
    cyc();
    chk("e3_setup_psel",  m_apb_psel, 8'h08);
    chk("e3_setup_paddr", m_apb_paddr, 7'h05);
    chk("e3_setup_pstrb", m_apb_pstrb, 4'h3);
    s_apb_penable = 1'b1;
    cyc();
    chk("e3_acc_penable", m_apb_penable, 1'b1);
    cyc();
    chk("e3_resp_pready",  s_apb_pready, 1'b1);
    chk("e3_resp_pslverr", s_apb_pslverr, 1'b1);
    cyc();
    chk("e3_idle_pready", s_apb_pready, 1'b0);
    up_setup(12'h010, 1'b0, 32'h0, 4'hF);
    set_slave_data(0, 32'hCAFE_F00D);
    cyc();
    chk("b2b_setup_psel",  m_apb_psel, 8'h01);
    chk("b2b_setup_paddr", m_apb_paddr, 7'h10);
    s_apb_penable = 1'b1;
    cyc();
    chk("b2b_acc_psel", m_apb_psel, 8'h01);
    cyc();
    chk("b2b_resp_pready",  s_apb_pready, 1'b1);
    chk("b2b_resp_prdata",  s_apb_prdata, 32'hCAFE_F00D);
    chk("b2b_resp_pslverr", s_apb_pslverr, 1'b0);
    up_idle();
    m_apb_pslverr = 8'h00;
    cyc();

    // Reset during a stalled ACCESS to slave 4, then a normal write to slave 2
    up_setup(12'h200, 1'b0, 32'h0, 4'hF);
    m_apb_pready = 8'hEF;
    cyc();
    chk("rs_setup_psel", m_apb_psel, 8'h10);
    s_apb_penable = 1'b1;
    cyc();
    cyc();
    chk("rs_stall_penable", m_apb_penable, 1'b1);
    chk("rs_stall_pready",  s_apb_pready, 1'b0);
    rst = 1'b1;
    cyc();
    chk("rs_after_psel",    m_apb_psel, 8'h00);
    chk("rs_after_penable", m_apb_penable, 1'b0);
    chk("rs_after_pready",  s_apb_pready, 1'b0);
    rst = 1'b0;
    up_idle();
    cyc();
    chk("rs_idle_psel", m_apb_psel, 8'h00);
    up_setup(12'h17F, 1'b1, 32'h0123_4567, 4'hF);
    m_apb_pready = 8'hFF;
    cyc();
    chk("rs_w2_psel",   m_apb_psel, 8'h04);
    chk("rs_w2_paddr",  m_apb_paddr, 7'h7F);
    chk("rs_w2_pwdata", m_apb_pwdata, 32'h0123_4567);
    s_apb_penable = 1'b1;
    cyc();
    cyc();
    chk("rs_w2_resp_pready",  s_apb_pready, 1'b1);
    chk("rs_w2_resp_pslverr", s_apb_pslverr, 1'b0);
    up_idle();
    cyc();

`ifdef APB_SPLITTER_TIMEOUT_EN
    // Slave 1 never ready: ACCESS lasts 16 cycles, then error response
    up_setup(12'h080, 1'b0, 32'h0, 4'hF);
    m_apb_pready = 8'hFD;
    set_slave_data(1, 32'h7777_7777);
    cyc();
    s_apb_penable = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      chk("to_acc_penable", m_apb_penable, 1'b1);
      chk("to_acc_psel",    m_apb_psel, 8'h02);
      cyc();
    end
    chk("to_resp_pready",  s_apb_pready, 1'b1);
    chk("to_resp_pslverr", s_apb_pslverr, 1'b1);
    chk("to_resp_prdata",  s_apb_prdata, 32'h0);
    chk("to_resp_psel",    m_apb_psel, 8'h00);
    m_apb_pready = 8'hFF;
    up_idle();
    cyc();
    chk("to_late_pready", s_apb_pready, 1'b0);
    chk("to_late_psel",   m_apb_psel, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
